debug_unit: RTL and testbench

//  Host-side initiator for the pipeline debug interface. Decodes UART command bytes, streams program

---
 rtl/debug_unit.sv | 173 +++++++++++++++++
 tb/tb_debug_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Host-side debug initiator: decodes UART commands, loads instruction memory, runs or steps the
// pipeline, then dumps PC, the register file and a data-memory window MSB-first over UART.
module debug_unit #(
  parameter int          NB_DATA        = 32,
  parameter int          NB_REG         = 5,
  parameter int          NB_ADDR        = 7,
  parameter int          N_REGISTER     = 32,
  parameter int          MEM_DUMP_WORDS = 32,
  parameter int          IMEM_DEPTH     = 256,
  parameter logic [31:0] HALT_WORD      = 32'hFFFF_FFFF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_done_i,
  output logic [7:0]         tx_data_o,
  output logic               tx_start_o,
  input  logic               tx_done_i,
  output logic [NB_DATA-1:0] data_inst_to_write,
  output logic               ready_instr_to_write,
  output logic [31:0]        o_dir_mem_write,
  output logic               en_pipeline,
  output logic               en_read_inst,
  output logic               select_debug_or_wireA,
  output logic [NB_REG-1:0]  addr_reg_debug,
  input  logic [NB_DATA-1:0] data_registers_debug,
  output logic               select_debug_or_alu_result,
  output logic [NB_ADDR-1:0] addr_mem_debug,
  input  logic [NB_DATA-1:0] data_mem_debug,
  input  logic [NB_DATA-1:0] data_pc_debug,
  input  logic               halt_signal_o_wb,
  output logic               halted_o
);
  localparam int N_WORDS = 1 + N_REGISTER + MEM_DUMP_WORDS;
  localparam int NB_WCNT = $clog2(N_WORDS + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_LOAD_WR, S_RUN_CONT, S_RUN_STEP,
    S_SETUP, S_SETTLE, S_LATCH, S_SEND, S_WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           bcnt_q, bcnt_d;
  logic [NB_DATA-1:0]   word_q, word_d;
  logic [31:0]          waddr_q, waddr_d;
  logic [NB_WCNT-1:0]   wcnt_q, wcnt_d;
  logic [NB_DATA-1:0]   dat_q, dat_d;
  logic                 halted_q, halted_d;
  logic                 rd_en_q;

  logic                 in_dump, is_reg, last_word;
  logic [NB_WCNT-1:0]   ridx, midx;

  // Word index 0 is the PC, then registers, then the memory window.
  assign ridx      = wcnt_q - NB_WCNT'(1);
  assign midx      = wcnt_q - NB_WCNT'(1 + N_REGISTER);
  assign is_reg    = (wcnt_q != '0) && (wcnt_q <= NB_WCNT'(N_REGISTER));
  assign last_word = (wcnt_q == NB_WCNT'(N_WORDS - 1));
  assign in_dump   = (state_q == S_SETUP) || (state_q == S_SETTLE) || (state_q == S_LATCH) ||
                     (state_q == S_SEND)  || (state_q == S_WAIT);

  assign select_debug_or_wireA      = in_dump;
  assign select_debug_or_alu_result = in_dump;
  assign addr_reg_debug     = in_dump ? NB_REG'(ridx) : '0;
  assign addr_mem_debug     = in_dump ? NB_ADDR'({midx, 2'b00}) : '0;
  assign tx_data_o          = (state_q == S_SEND || state_q == S_WAIT) ? dat_q[NB_DATA-1 -: 8] : 8'h00;
  assign data_inst_to_write = word_q;
  assign o_dir_mem_write    = waddr_q;
  assign en_read_inst       = rd_en_q;
  assign halted_o           = halted_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      word_q   <= '0;
      waddr_q  <= '0;
      wcnt_q   <= '0;
      dat_q    <= '0;
      halted_q <= 1'b0;
      rd_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      word_q   <= word_d;
      waddr_q  <= waddr_d;
      wcnt_q   <= wcnt_d;
      dat_q    <= dat_d;
      halted_q <= halted_d;
      rd_en_q  <= (state_d != S_LOAD) && (state_d != S_LOAD_WR);
    end
  end

  always_comb begin
    state_d              = state_q;
    bcnt_d               = bcnt_q;
    word_d               = word_q;
    waddr_d              = waddr_q;
    wcnt_d               = wcnt_q;
    dat_d                = dat_q;
    halted_d             = halted_q;
    tx_start_o           = 1'b0;
    ready_instr_to_write = 1'b0;
    en_pipeline          = 1'b0;
    case (state_q)
      S_IDLE: if (rx_done_i) begin
        case (rx_data_i)
          8'h4C: begin
            state_d  = S_LOAD;
            halted_d = 1'b0;
            waddr_d  = '0;
            bcnt_d   = '0;
          end
          8'h43: if (!halted_q) state_d = S_RUN_CONT;
          8'h53: if (!halted_q) state_d = S_RUN_STEP;
          default: ;
        endcase
      end
      S_LOAD: if (rx_done_i) begin
        word_d = {word_q[NB_DATA-9:0], rx_data_i};
        bcnt_d = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) state_d = S_LOAD_WR;
      end
      S_LOAD_WR: begin
        // Words past the end of instruction memory are consumed but never written.
        ready_instr_to_write = ((waddr_q >> 2) < 32'(IMEM_DEPTH));
        waddr_d = waddr_q + 32'd4;
        state_d = (word_q == HALT_WORD) ? S_IDLE : S_LOAD;
      end
      S_RUN_CONT: begin
        en_pipeline = 1'b1;
        if (halt_signal_o_wb) begin
          halted_d = 1'b1;
          state_d  = S_SETUP;
          wcnt_d   = '0;
          bcnt_d   = '0;
        end
      end
      S_RUN_STEP: begin
        en_pipeline = 1'b1;
        if (halt_signal_o_wb) halted_d = 1'b1;
        state_d = S_SETUP;
        wcnt_d  = '0;
        bcnt_d  = '0;
      end
      S_SETUP:  state_d = S_SETTLE;
      S_SETTLE: state_d = S_LATCH;
      S_LATCH: begin
        dat_d   = (wcnt_q == '0) ? data_pc_debug : (is_reg ? data_registers_debug : data_mem_debug);
        state_d = S_SEND;
      end
      S_SEND: begin
        tx_start_o = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: if (tx_done_i) begin
        if (bcnt_q == 2'd3) begin
          bcnt_d = '0;
          if (last_word) state_d = S_IDLE;
          else begin
            wcnt_d  = wcnt_q + NB_WCNT'(1);
            state_d = S_SETUP;
          end
        end else begin
          bcnt_d  = bcnt_q + 2'd1;
          dat_d   = {dat_q[NB_DATA-9:0], 8'h00};
          state_d = S_SEND;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: stimulus pushes expected imem writes and UART bytes,
// independent monitors pop and compare as the DUT strobes them.
module tb_debug_unit;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_done_i = 1'b0;
  logic [7:0]  tx_data_o;
  logic        tx_start_o;
  logic        tx_done_i = 1'b0;
  logic [31:0] data_inst_to_write;
  logic        ready_instr_to_write;
  logic [31:0] o_dir_mem_write;
  logic        en_pipeline, en_read_inst;
  logic        select_debug_or_wireA, select_debug_or_alu_result;
  logic [4:0]  addr_reg_debug;
  logic [31:0] data_registers_debug, data_mem_debug, data_pc_debug;
  logic [6:0]  addr_mem_debug;
  logic        halt_signal_o_wb = 1'b0;
  logic        halted_o;
  logic [31:0] pc_val = 32'h0;

  logic [7:0]  byte_q[$];
  logic [63:0] wr_q[$];
  int nvec = 0, nfail = 0, en_cnt = 0, tx_cnt = 0, halt_at = 0, tx_delay = 3, t0;

  debug_unit dut (
    .clock(clock), .reset(reset), .rx_data_i(rx_data_i), .rx_done_i(rx_done_i),
    .tx_data_o(tx_data_o), .tx_start_o(tx_start_o), .tx_done_i(tx_done_i),
    .data_inst_to_write(data_inst_to_write), .ready_instr_to_write(ready_instr_to_write),
    .o_dir_mem_write(o_dir_mem_write), .en_pipeline(en_pipeline), .en_read_inst(en_read_inst),
    .select_debug_or_wireA(select_debug_or_wireA), .addr_reg_debug(addr_reg_debug),
    .data_registers_debug(data_registers_debug),
    .select_debug_or_alu_result(select_debug_or_alu_result), .addr_mem_debug(addr_mem_debug),
    .data_mem_debug(data_mem_debug), .data_pc_debug(data_pc_debug),
    .halt_signal_o_wb(halt_signal_o_wb), .halted_o(halted_o)
  );

  initial forever #5 clock = ~clock;

  function automatic logic [31:0] reg_model(input logic [4:0] i);
    return (i == 5'd1) ? 32'hDEAD_BEEF : {3'b0, i, 8'h5A, 3'b0, i, 8'hC3};
  endfunction
  function automatic logic [31:0] mem_model(input logic [6:0] a);
    return {8'h10, 1'b0, a, 8'h77, 1'b0, ~a};
  endfunction

  // Environment only answers while the debug selects are asserted.
  assign data_registers_debug = select_debug_or_wireA ? reg_model(addr_reg_debug) : 32'hBAD0_BAD0;
  assign data_mem_debug       = select_debug_or_alu_result ? mem_model(addr_mem_debug) : 32'hBAD1_BAD1;
  assign data_pc_debug        = pc_val;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({tx_data_o, tx_start_o, data_inst_to_write, ready_instr_to_write, o_dir_mem_write,
                 en_pipeline, en_read_inst, select_debug_or_wireA, addr_reg_debug,
                 select_debug_or_alu_result, addr_mem_debug, halted_o});
  endfunction

  task automatic push_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) byte_q.push_back(w[8*b +: 8]);
  endtask

  task automatic push_dump(input logic [31:0] pc);
    push_word(pc);
    for (int i = 0; i < 32; i++) push_word(reg_model(5'(i)));
    for (int k = 0; k < 32; k++) push_word(mem_model(7'(4 * k)));
  endtask

  // Monitor: pipeline enable counting, halt injection, write and byte scoreboards.
  initial forever begin
    @(negedge clock);
    if (en_pipeline) en_cnt++;
    halt_signal_o_wb = en_pipeline && (halt_at != 0) && (en_cnt == halt_at);
    if (ready_instr_to_write) begin
      if (wr_q.size() == 0) check("imem_wr_unexpected", 128'({o_dir_mem_write, data_inst_to_write}), 128'hx);
      else check("imem_wr", 128'({o_dir_mem_write, data_inst_to_write}), 128'(wr_q.pop_front()));
    end
    if (tx_start_o) begin
      tx_cnt++;
      if (byte_q.size() == 0) check("tx_unexpected", 128'(tx_data_o), 128'hx);
      else check("tx_byte", 128'(tx_data_o), 128'(byte_q.pop_front()));
    end
  end

  // UART transmitter model: tx_done_i after tx_delay cycles, data must hold meanwhile.
  initial forever begin
    logic [7:0] d;
    logic rs;
    @(negedge clock);
    tx_done_i = 1'b0;
    if (tx_start_o) begin
      d = tx_data_o;
      rs = 1'b0;
      for (int k = 0; k < tx_delay; k++) begin
        @(negedge clock);
        if (reset) rs = 1'b1;
      end
      if (!rs) check("tx_hold", 128'(tx_data_o), 128'(d));
      tx_done_i = 1'b1;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    rx_data_i = b;
    rx_done_i = 1'b1;
    @(negedge clock);
    rx_done_i = 1'b0;
    @(negedge clock);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8]);
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while ((byte_q.size() != 0 || wr_q.size() != 0) && n < max) begin
      @(negedge clock);
      n++;
    end
    repeat (tx_delay + 8) @(negedge clock);
    check(name, 128'(byte_q.size() + wr_q.size()), 128'd0);
    byte_q.delete();
    wr_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset_outs", all_outs(), 128'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rd_en_idle", 128'(en_read_inst), 128'd1);

    // Basic load terminated by the halt word.
    wr_q.push_back({32'h0, 32'h2001_0005});
    wr_q.push_back({32'h4, 32'hFFFF_FFFF});
    send_byte(8'h4C);
    check("rd_en_load", 128'({en_read_inst, en_pipeline}), 128'd0);
    send_word(32'h2001_0005);
    send_word(32'hFFFF_FFFF);
    wait_drain("load_basic", 200);
    check("rd_en_after_load", 128'(en_read_inst), 128'd1);

    // Words beyond instruction memory depth produce no strobe.
    for (int i = 0; i < 256; i++) wr_q.push_back({32'(4 * i), 32'(i + 1)});
    send_byte(8'h4C);
    for (int i = 0; i < 256; i++) send_word(32'(i + 1));
    send_word(32'h1234_5678);
    send_word(32'hFFFF_FFFF);
    wait_drain("load_depth", 200);

    // Two single steps, PC advancing between them.
    en_cnt = 0;
    push_dump(32'h0);
    send_byte(8'h53);
    wait_drain("step1_dump", 5000);
    check("step1_en", 128'(en_cnt), 128'd1);
    pc_val = 32'h4;
    en_cnt = 0;
    push_dump(32'h4);
    send_byte(8'h53);
    wait_drain("step2_dump", 5000);
    check("step2_en", 128'(en_cnt), 128'd1);
    check("step_not_halted", 128'(halted_o), 128'd0);

    // Continuous run halting on the 10th enable cycle, slow transmitter, stray rx mid-dump.
    tx_delay = 100;
    halt_at = 10;
    en_cnt = 0;
    pc_val = 32'h28;
    t0 = tx_cnt;
    push_dump(32'h28);
    send_byte(8'h43);
    for (int n = 0; n < 5000 && tx_cnt - t0 < 5; n++) @(negedge clock);
    send_byte(8'h4C);
    wait_drain("cont_dump", 60000);
    check("cont_en", 128'(en_cnt), 128'd10);
    check("cont_halted", 128'(halted_o), 128'd1);
    check("cont_tx_bytes", 128'(tx_cnt - t0), 128'd260);
    halt_at = 0;
    tx_delay = 3;

    // Run commands ignored while halted.
    en_cnt = 0;
    t0 = tx_cnt;
    send_byte(8'h43);
    send_byte(8'h53);
    repeat (30) @(negedge clock);
    check("halted_ignore_en", 128'(en_cnt), 128'd0);
    check("halted_ignore_tx", 128'(tx_cnt - t0), 128'd0);

    // Reload clears halted, step accepted again.
    wr_q.push_back({32'h0, 32'hFFFF_FFFF});
    send_byte(8'h4C);
    send_word(32'hFFFF_FFFF);
    wait_drain("reload", 200);
    check("reload_unhalted", 128'(halted_o), 128'd0);
    en_cnt = 0;
    push_dump(32'h28);
    send_byte(8'h53);
    wait_drain("step3_dump", 5000);
    check("step3_en", 128'(en_cnt), 128'd1);

    // Reset in the middle of a dump.
    t0 = tx_cnt;
    push_dump(32'h28);
    send_byte(8'h53);
    for (int n = 0; n < 5000 && tx_cnt - t0 < 10; n++) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midreset_outs", all_outs(), 128'd0);
    byte_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    t0 = tx_cnt;
    repeat (200) @(negedge clock);
    check("midreset_no_tx", 128'(tx_cnt - t0), 128'd0);
    check("midreset_rd_en", 128'(en_read_inst), 128'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
